debug_trace_fifo: RTL and testbench

Parametrised, synthesizable successor to the simulation-only PE debug port. It captures memory-mapped debug writes from the PE into a timestamped trace FIFO instead of printing them. Records are delivered over a valid/ready stream to an on-chip trace collector, which sits between the PE bus and the NoC-side debug link. Supports N decoded channels, a runtime channel mask, drop or stall overflow policy with loss markers, and a sticky halt request.

---
 rtl/debug_trace_fifo.sv | 191 +++++++++++++++++++
 tb/tb_debug_trace_fifo.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_fifo.sv
// debug_trace_fifo: captures memory-mapped debug writes from the PE into a
// timestamped first-word-fall-through trace FIFO. Records go out over a
// valid/ready stream. Overflow either back-pressures the writer (STALL_MODE=1)
// or drops the record, counts it and later inserts a loss marker (STALL_MODE=0).
module debug_trace_fifo #(
    parameter int unsigned NUM_CH     = 16,
    parameter int unsigned DEPTH      = 8,
    parameter bit          STALL_MODE = 1'b0,
    parameter logic [23:0] CH_BASE    = 24'h000100,
    parameter logic [23:0] HALT_ADDR  = 24'h000004,
    parameter logic [23:0] CTRL_ADDR  = 24'h0000FC,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [23:0]       addr_i,
    input  logic [31:0]       data_i,
    input  logic [63:0]       tick_cntr_i,
    output logic              stall_o,
    output logic              trace_valid_o,
    input  logic              trace_ready_i,
    output logic              trace_marker_o,
    output logic [CH_W-1:0]   trace_chan_o,
    output logic [31:0]       trace_data_o,
    output logic [63:0]       trace_tick_o,
    output logic              halt_o,
    output logic [15:0]       drop_cnt_o,
    output logic [LVL_W-1:0]  level_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [23:0] WIN   = 24'(4 * NUM_CH);

    // Bus decode
    logic              wr_req;
    logic [23:0]       offset;
    logic              in_win;
    logic              aligned;
    logic [CH_W-1:0]   chan;
    logic [NUM_CH-1:0] mask;
    logic              hit;

    assign wr_req  = en_i && we_i;
    assign offset  = addr_i - CH_BASE;
    assign in_win  = (addr_i >= CH_BASE) && (offset < WIN);
    assign aligned = (addr_i[1:0] == 2'b00);
    assign chan    = offset[CH_W+1:2];
    assign hit     = wr_req && in_win && aligned && mask[chan];

    // FIFO storage and bookkeeping
    logic              mem_marker [DEPTH];
    logic [CH_W-1:0]   mem_chan   [DEPTH];
    logic [31:0]       mem_data   [DEPTH];
    logic [63:0]       mem_tick   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;

    logic              valid;
    logic              full;
    logic              pop;
    logic              space;

    assign valid = (level != '0);
    assign full  = (level == LVL_W'(DEPTH));
    assign pop   = valid && trace_ready_i;
    assign space = !full || pop;

    // Overflow tracking (drop mode)
    logic [15:0]       drop_cnt;
    logic [15:0]       ivl;
    logic              marker_pend;

    // Push/drop decision for this cycle
    logic              push;
    logic              push_marker;
    logic              drop;
    logic              w_marker;
    logic [CH_W-1:0]   w_chan;
    logic [31:0]       w_data;

    // Choose what (if anything) enters the FIFO; a pending loss marker wins
    // over a concurrent hit, which then becomes the first drop of a new interval.
    always_comb begin
        push        = 1'b0;
        push_marker = 1'b0;
        drop        = 1'b0;
        if (STALL_MODE) begin
            push = hit && space;
        end else if (marker_pend && space) begin
            push        = 1'b1;
            push_marker = 1'b1;
            drop        = hit;
        end else if (hit) begin
            if (space) begin
                push = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // Record contents to be written on a push
    always_comb begin
        w_marker = push_marker;
        w_chan   = push_marker ? '0 : chan;
        w_data   = push_marker ? {16'h0000, ivl} : data_i;
    end

    assign stall_o = STALL_MODE && hit && !space;

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_marker[i] <= 1'b0;
                mem_chan[i]   <= '0;
                mem_data[i]   <= '0;
                mem_tick[i]   <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem_marker[wr_ptr] <= w_marker;
                mem_chan[wr_ptr]   <= w_chan;
                mem_data[wr_ptr]   <= w_data;
                mem_tick[wr_ptr]   <= tick_cntr_i;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Drop counter, per-interval loss count and marker request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt    <= '0;
            ivl         <= '0;
            marker_pend <= 1'b0;
        end else begin
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (push_marker) begin
                ivl         <= drop ? 16'd1 : 16'd0;
                marker_pend <= drop;
            end else if (drop) begin
                if (ivl != '1) begin
                    ivl <= ivl + 16'd1;
                end
                marker_pend <= 1'b1;
            end
        end
    end

    // Sticky halt request and runtime channel mask
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halt_o <= 1'b0;
            mask   <= '1;
        end else begin
            if (wr_req && (addr_i == HALT_ADDR)) begin
                halt_o <= 1'b1;
            end
            if (wr_req && (addr_i == CTRL_ADDR)) begin
                mask <= NUM_CH'({32'h0000_0000, data_i});
            end
        end
    end

    assign trace_valid_o  = valid;
    assign trace_marker_o = mem_marker[rd_ptr];
    assign trace_chan_o   = mem_chan[rd_ptr];
    assign trace_data_o   = mem_data[rd_ptr];
    assign trace_tick_o   = mem_tick[rd_ptr];
    assign drop_cnt_o     = drop_cnt;
    assign level_o        = level;

endmodule

// File: tb/tb_debug_trace_fifo.sv
// Self-checking bench for debug_trace_fifo: one drop-mode and one stall-mode
// instance share the same bus stimulus; a queue-based model tracks each.
module tb_debug_trace_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en, we, ready;
    logic [23:0] addr;
    logic [31:0] data;
    logic [63:0] tick;

    logic        d_stall, d_valid, d_marker, d_halt;
    logic [3:0]  d_chan, d_level;
    logic [31:0] d_data;
    logic [63:0] d_tick;
    logic [15:0] d_drops;

    logic        s_stall, s_valid, s_marker, s_halt;
    logic [3:0]  s_chan, s_level;
    logic [31:0] s_data;
    logic [63:0] s_tick;
    logic [15:0] s_drops;

    always #5 clk = ~clk;

    debug_trace_fifo #(.NUM_CH(16), .DEPTH(DEPTH), .STALL_MODE(1'b0)) u_drop (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .we_i(we), .addr_i(addr),
        .data_i(data), .tick_cntr_i(tick), .stall_o(d_stall),
        .trace_valid_o(d_valid), .trace_ready_i(ready), .trace_marker_o(d_marker),
        .trace_chan_o(d_chan), .trace_data_o(d_data), .trace_tick_o(d_tick),
        .halt_o(d_halt), .drop_cnt_o(d_drops), .level_o(d_level)
    );

    debug_trace_fifo #(.NUM_CH(16), .DEPTH(DEPTH), .STALL_MODE(1'b1)) u_stall (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .we_i(we), .addr_i(addr),
        .data_i(data), .tick_cntr_i(tick), .stall_o(s_stall),
        .trace_valid_o(s_valid), .trace_ready_i(ready), .trace_marker_o(s_marker),
        .trace_chan_o(s_chan), .trace_data_o(s_data), .trace_tick_o(s_tick),
        .halt_o(s_halt), .drop_cnt_o(s_drops), .level_o(s_level)
    );

    typedef struct {
        bit          mk;
        int unsigned ch;
        logic [31:0] d;
        logic [63:0] t;
    } rec_t;

    rec_t        qd[$];
    rec_t        qs[$];
    logic [15:0] m_mask;
    bit          m_halt;
    int unsigned m_drops;
    int unsigned m_ivl;
    bit          m_pend;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit();
        int unsigned off;
        if (!(en && we) || addr < 24'h000100) return 1'b0;
        off = 32'(addr) - 32'h100;
        if (off >= 64 || (off % 4) != 0) return 1'b0;
        return m_mask[off / 4];
    endfunction

    task automatic model_reset();
        qd.delete();
        qs.delete();
        m_mask  = 16'hFFFF;
        m_halt  = 1'b0;
        m_drops = 0;
        m_ivl   = 0;
        m_pend  = 1'b0;
    endtask

    task automatic count_drop();
        if (m_drops < 65535) m_drops++;
    endtask

    // Model of one clock edge, using the inputs presented during the cycle.
    task automatic model_edge();
        bit   h, popd, pops, spd, sps;
        rec_t r, m;
        h    = model_hit();
        popd = (qd.size() > 0) && ready;
        pops = (qs.size() > 0) && ready;
        spd  = (qd.size() < DEPTH) || popd;
        sps  = (qs.size() < DEPTH) || pops;
        r.mk = 1'b0;
        r.ch = (32'(addr) - 32'h100) / 4;
        r.d  = data;
        r.t  = tick;
        m.mk = 1'b1;
        m.ch = 0;
        m.d  = m_ivl;
        m.t  = tick;
        if (popd) void'(qd.pop_front());
        if (m_pend && spd) begin
            qd.push_back(m);
            if (h) begin
                count_drop();
                m_ivl = 1;
            end else begin
                m_ivl  = 0;
                m_pend = 1'b0;
            end
        end else if (h) begin
            if (spd) begin
                qd.push_back(r);
            end else begin
                count_drop();
                if (m_ivl < 65535) m_ivl++;
                m_pend = 1'b1;
            end
        end
        if (pops) void'(qs.pop_front());
        if (h && sps) qs.push_back(r);
        if (en && we && addr == 24'h000004) m_halt = 1'b1;
        if (en && we && addr == 24'h0000FC) m_mask = data[15:0];
    endtask

    task automatic check_outputs();
        chk("d_valid", d_valid, qd.size() != 0);
        chk("d_level", d_level, 64'(qd.size()));
        if (qd.size() > 0) begin
            chk("d_marker", d_marker, qd[0].mk);
            chk("d_chan", d_chan, qd[0].ch);
            chk("d_data", d_data, qd[0].d);
            chk("d_tick", d_tick, qd[0].t);
        end
        chk("d_drops", d_drops, m_drops);
        chk("d_halt", d_halt, m_halt);
        chk("s_valid", s_valid, qs.size() != 0);
        chk("s_level", s_level, 64'(qs.size()));
        if (qs.size() > 0) begin
            chk("s_marker", s_marker, qs[0].mk);
            chk("s_chan", s_chan, qs[0].ch);
            chk("s_data", s_data, qs[0].d);
            chk("s_tick", s_tick, qs[0].t);
        end
        chk("s_drops", s_drops, 16'h0000);
        chk("s_halt", s_halt, m_halt);
    endtask

    // One clock cycle: inputs are already set (posedge+1); check stall, clock, check state.
    task automatic step();
        bit h, sps;
        #1;
        h   = model_hit();
        sps = (qs.size() < DEPTH) || ((qs.size() > 0) && ready);
        chk("s_stall", s_stall, h && !sps);
        chk("d_stall", d_stall, 1'b0);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        tick = tick + 64'd1;
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d);
        en = 1'b1; we = 1'b1; addr = a; data = d;
    endtask

    task automatic idle();
        en = 1'b0; we = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", d_valid, 1'b0);
        chk("rst_level", d_level, 4'd0);
        chk("rst_data", d_data, 32'h0);
        chk("rst_tick", d_tick, 64'h0);
        chk("rst_marker", d_marker, 1'b0);
        chk("rst_chan", d_chan, 4'd0);
        chk("rst_sstall", s_stall, 1'b0);
        check_outputs();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        int unsigned sel;
        int unsigned saved_drops;
        en = 1'b0; we = 1'b0; addr = '0; data = '0; tick = '0; ready = 1'b0;
        do_reset();

        // Single write, channel 2
        tick = 64'd100;
        wr(24'h000108, 32'h0000CAFE);
        step();
        idle();
        chk("t1_valid", d_valid, 1'b1);
        chk("t1_chan", d_chan, 4'd2);
        chk("t1_data", d_data, 32'h0000CAFE);
        chk("t1_tick", d_tick, 64'd100);
        chk("t1_marker", d_marker, 1'b0);
        ready = 1'b1;
        step();
        chk("t1_level", d_level, 4'd0);

        // Overflow in drop mode: 11 hits into 8 entries
        ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            wr(24'h000100 + 24'(4 * (i % 16)), $urandom);
            step();
        end
        idle();
        chk("t2_level", d_level, 4'd8);
        chk("t2_drops", d_drops, 16'd3);
        chk("t2_slevel", s_level, 4'd8);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("t2_marker", d_marker, 1'b1);
        chk("t2_mdata", d_data, 32'd3);
        chk("t2_mchan", d_chan, 4'd0);
        step();
        chk("t2_empty", d_valid, 1'b0);

        // Stall mode: full FIFO, write held 5 cycles, ready raised on the third
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(24'h000100 + 24'(4 * i), 32'h1000 + 32'(i));
            step();
        end
        for (int i = 0; i < 5; i++) begin
            ready = (i >= 2);
            wr(24'h00010C, 32'h00003333);
            #1;
            chk("t3_stall", s_stall, i < 2);
            step();
        end
        idle();
        chk("t3_slevel", s_level, 4'd8);
        chk("t3_sdrops", s_drops, 16'd0);
        ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("t3_empty", d_valid, 1'b0);

        // Channel mask: only channel 0 enabled
        ready = 1'b0;
        saved_drops = m_drops;
        wr(24'h0000FC, 32'h0000_0001);
        step();
        wr(24'h000100, 32'h11);
        step();
        wr(24'h000104, 32'h22);
        step();
        idle();
        chk("t4_level", d_level, 4'd1);
        chk("t4_data", d_data, 32'h11);
        chk("t4_chan", d_chan, 4'd0);
        chk("t4_drops", d_drops, 16'(saved_drops));
        wr(24'h0000FC, 32'h0000_FFFF);
        step();
        idle();
        ready = 1'b1;
        step();

        // Sticky halt
        wr(24'h000004, 32'h1);
        step();
        chk("t5_halt", d_halt, 1'b1);
        for (int i = 0; i < 6; i++) begin
            wr(24'h000100 + 24'(4 * $urandom_range(0, 15)), $urandom);
            step();
        end
        idle();
        step();
        chk("t5_halt_hold", d_halt, 1'b1);
        do_reset();
        chk("t5_halt_rst", d_halt, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            sel   = $urandom_range(0, 39);
            ready = ($urandom_range(0, 3) != 0) ^ (((i / 64) % 2) == 1);
            data  = $urandom;
            if (sel < 24) begin
                wr(24'h000100 + 24'(4 * $urandom_range(0, 15)), data);
            end else if (sel < 27) begin
                wr(24'h000100 + 24'(4 * $urandom_range(0, 15)) + 24'($urandom_range(1, 3)), data);
            end else if (sel < 29) begin
                wr(($urandom_range(0, 1) == 1) ? 24'h000140 + 24'(4 * $urandom_range(0, 15)) : 24'h0000F0, data);
            end else if (sel == 29 && $urandom_range(0, 9) == 0) begin
                wr(24'h000004, data);
            end else if (sel == 30) begin
                wr(24'h0000FC, data | 32'h0000_0F0F);
            end else if (sel < 34) begin
                en = 1'b1; we = 1'b0;
                addr = 24'h000100 + 24'(4 * $urandom_range(0, 15));
            end else begin
                idle();
            end
            step();
        end
        idle();

        // Full FIFO streaming at one record per cycle, then async reset mid-burst
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(24'h000100 + 24'(4 * i), 32'hA000 + 32'(i));
            step();
        end
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr(24'h000100 + 24'(4 * (i % 16)), 32'hB000 + 32'(i));
            step();
            chk("t6_level", d_level, 4'd8);
            chk("t6_drops", d_drops, 16'd0);
        end
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_valid", d_valid, 1'b0);
        chk("t6_rst_level", d_level, 4'd0);
        chk("t6_rst_svalid", s_valid, 1'b0);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
